// File: rtl/gate_list_executor.sv
// Gate control list executor for one egress port.
// Per-queue gate states come from a double-buffered list (admin/oper). A committed
// admin list is swapped into oper at the next cycle start, or at once while disabled.
// Optional feature macro: GATE_GUARD_BAND_EN. When it is defined, an entry whose
// guard-band flag is set closes all gates for its final guard_band clocks.
module gate_list_executor #(
   parameter int unsigned NUM_QUEUES     = 8,
   parameter int unsigned LIST_DEPTH     = 16,
   parameter int unsigned INTERVAL_W     = 20,
   parameter int unsigned INTERVAL_SHIFT = 8,
   parameter int unsigned GB_W           = 20
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            gate_enable,
   input  logic                            cycle_start,
   input  logic [NUM_QUEUES-1:0]           admin_gate_states,
   input  logic                            cfg_wr,
   input  logic [$clog2(LIST_DEPTH)-1:0]   cfg_addr,
   input  logic [NUM_QUEUES:0]             cfg_entry,
   input  logic [INTERVAL_W-1:0]           cfg_interval,
   input  logic                            cfg_list_len_wr,
   input  logic [$clog2(LIST_DEPTH):0]     cfg_list_len,
   input  logic [GB_W-1:0]                 cfg_guard_band,
   input  logic                            cfg_commit,
   output logic                            config_pending,
   output logic [NUM_QUEUES-1:0]           out_gate_states,
   output logic [$clog2(LIST_DEPTH)-1:0]   list_pointer,
   output logic                            cycle_overrun
);

   localparam int unsigned IDX_W   = $clog2(LIST_DEPTH);
   localparam int unsigned LEN_W   = IDX_W + 1;
   localparam int unsigned DWELL_W = INTERVAL_W + INTERVAL_SHIFT;
   localparam logic [INTERVAL_W-1:0] RST_IVAL = INTERVAL_W'(1024);
   localparam logic [IDX_W-1:0]      IDX0     = '0;
`ifdef GATE_GUARD_BAND_EN
   localparam int unsigned CMP_W  = (DWELL_W > GB_W) ? DWELL_W : GB_W;
   localparam logic [GB_W-1:0] RST_GB = GB_W'(3200);
`endif

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_WAIT     = 2'd1,
      ST_RUN      = 2'd2,
      ST_HOLD     = 2'd3
   } state_e;

   // Admin bank (written by configuration)
   logic [NUM_QUEUES-1:0] adm_gates_q [LIST_DEPTH];
   logic [INTERVAL_W-1:0] adm_ival_q  [LIST_DEPTH];
   logic [LIST_DEPTH-1:0] adm_gb_flag_q;
   logic [LEN_W-1:0]      adm_len_q;

   // Oper bank (loaded only by a swap)
   logic [NUM_QUEUES-1:0] opr_gates_q [LIST_DEPTH];
   logic [INTERVAL_W-1:0] opr_ival_q  [LIST_DEPTH];
   logic [LIST_DEPTH-1:0] opr_gb_flag_q;
   logic [LEN_W-1:0]      opr_len_q;

`ifdef GATE_GUARD_BAND_EN
   logic [GB_W-1:0]       adm_gb_len_q;
   logic [GB_W-1:0]       opr_gb_len_q;
   logic [GB_W-1:0]       cur_gb_len;
   logic                  cur_gb_flag;
`else
   logic                  unused_gb;
`endif

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [DWELL_W-1:0]    timer_q, timer_d;
   logic                  pend_q, pend_d;
   logic                  ovr_q, ovr_d;
   logic [NUM_QUEUES-1:0] out_q, out_d;
   logic                  swap;
   logic [NUM_QUEUES-1:0] cur_gates;
   logic                  gb_close;

   // Dwell of an entry minus one; a zero dwell counts as one clock
   function automatic logic [DWELL_W-1:0] dwell_m1(input logic [INTERVAL_W-1:0] iv);
      logic [DWELL_W-1:0] d;
      d = DWELL_W'(iv) << INTERVAL_SHIFT;
      if (d == '0) d = DWELL_W'(1);
      return d - DWELL_W'(1);
   endfunction

   // List length is stored within 1..LIST_DEPTH
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
      if (l == '0) return LEN_W'(1);
      if (l > LEN_W'(LIST_DEPTH)) return LEN_W'(LIST_DEPTH);
      return l;
   endfunction

   // Admin bank: configuration writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < LIST_DEPTH; i++) begin
            adm_gates_q[IDX_W'(i)] <= '1;
            adm_ival_q[IDX_W'(i)]  <= RST_IVAL;
         end
         adm_gb_flag_q <= '0;
         adm_len_q     <= LEN_W'(LIST_DEPTH);
`ifdef GATE_GUARD_BAND_EN
         adm_gb_len_q  <= RST_GB;
`endif
      end else begin
         if (cfg_wr) begin
            adm_gates_q[cfg_addr]   <= cfg_entry[NUM_QUEUES-1:0];
            adm_gb_flag_q[cfg_addr] <= cfg_entry[NUM_QUEUES];
            adm_ival_q[cfg_addr]    <= cfg_interval;
         end
         if (cfg_list_len_wr) begin
            adm_len_q    <= clamp_len(cfg_list_len);
`ifdef GATE_GUARD_BAND_EN
            adm_gb_len_q <= cfg_guard_band;
`endif
         end
      end
   end

   // Oper bank: whole-list copy of admin on a swap edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < LIST_DEPTH; i++) begin
            opr_gates_q[IDX_W'(i)] <= '1;
            opr_ival_q[IDX_W'(i)]  <= RST_IVAL;
         end
         opr_gb_flag_q <= '0;
         opr_len_q     <= LEN_W'(LIST_DEPTH);
`ifdef GATE_GUARD_BAND_EN
         opr_gb_len_q  <= RST_GB;
`endif
      end else if (swap) begin
         for (int unsigned i = 0; i < LIST_DEPTH; i++) begin
            opr_gates_q[IDX_W'(i)] <= adm_gates_q[IDX_W'(i)];
            opr_ival_q[IDX_W'(i)]  <= adm_ival_q[IDX_W'(i)];
         end
         opr_gb_flag_q <= adm_gb_flag_q;
         opr_len_q     <= adm_len_q;
`ifdef GATE_GUARD_BAND_EN
         opr_gb_len_q  <= adm_gb_len_q;
`endif
      end
   end

   // Control state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_DISABLED;
         ptr_q   <= '0;
         timer_q <= '0;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
         out_q   <= '1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         timer_q <= timer_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         out_q   <= out_d;
      end
   end

   // Next state, list walk, swap decision and next gate outputs
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      timer_d   = timer_q;
      pend_d    = pend_q;
      ovr_d     = 1'b0;
      out_d     = out_q;
      swap      = 1'b0;
      cur_gates = '0;
      gb_close  = 1'b0;
`ifdef GATE_GUARD_BAND_EN
      cur_gb_len  = '0;
      cur_gb_flag = 1'b0;
`endif

      if (!gate_enable) begin
         state_d = ST_DISABLED;
         ptr_d   = '0;
         timer_d = '0;
         swap    = pend_q;
      end else if (cycle_start) begin
         state_d = ST_RUN;
         ptr_d   = '0;
         swap    = pend_q;
         ovr_d   = (state_q == ST_RUN);
         timer_d = dwell_m1(pend_q ? adm_ival_q[IDX0] : opr_ival_q[IDX0]);
      end else begin
         unique case (state_q)
            ST_DISABLED: state_d = ST_WAIT;
            ST_RUN: begin
               if (timer_q == '0) begin
                  if ((LEN_W'(ptr_q) + LEN_W'(1)) < opr_len_q) begin
                     ptr_d   = ptr_q + IDX_W'(1);
                     timer_d = dwell_m1(opr_ival_q[ptr_q + IDX_W'(1)]);
                  end else begin
                     state_d = ST_HOLD;
                  end
               end else begin
                  timer_d = timer_q - DWELL_W'(1);
               end
            end
            default: ;
         endcase
      end

      if (swap) pend_d = 1'b0;
      if (cfg_commit) pend_d = 1'b1;

      // On a swap edge the entry comes from the list being swapped in
      cur_gates = swap ? adm_gates_q[ptr_d] : opr_gates_q[ptr_d];
`ifdef GATE_GUARD_BAND_EN
      cur_gb_flag = swap ? adm_gb_flag_q[ptr_d] : opr_gb_flag_q[ptr_d];
      cur_gb_len  = swap ? adm_gb_len_q : opr_gb_len_q;
      gb_close    = cur_gb_flag && (CMP_W'(timer_d) < CMP_W'(cur_gb_len));
`endif

      case (state_d)
         ST_DISABLED: out_d = admin_gate_states;
         ST_WAIT:     out_d = out_q;
         ST_RUN:      out_d = gb_close ? '0 : cur_gates;
         ST_HOLD:     out_d = cur_gates;
         default:     out_d = out_q;
      endcase
   end

`ifndef GATE_GUARD_BAND_EN
   // Guard-band configuration is accepted but has no effect in this build
   assign unused_gb = ^{cfg_guard_band, opr_gb_flag_q};
`endif

   assign config_pending  = pend_q;
   assign out_gate_states = out_q;
   assign list_pointer    = ptr_q;
   assign cycle_overrun   = ovr_q;

endmodule

// File: tb/tb_gate_list_executor.sv
// Self-checking bench for gate_list_executor: directed table, multi-cycle
// sequences and randomized traffic against a time-since-cycle-start model.
module tb_gate_list_executor;

   localparam int NQ = 8;
   localparam int LD = 16;

`ifdef GATE_GUARD_BAND_EN
   localparam bit GB_EN = 1'b1;
`else
   localparam bit GB_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          gate_enable;
   logic          cycle_start;
   logic [NQ-1:0] admin_gate_states;
   logic          cfg_wr;
   logic [3:0]    cfg_addr;
   logic [NQ:0]   cfg_entry;
   logic [19:0]   cfg_interval;
   logic          cfg_list_len_wr;
   logic [4:0]    cfg_list_len;
   logic [19:0]   cfg_guard_band;
   logic          cfg_commit;
   logic          config_pending;
   logic [NQ-1:0] out_gate_states;
   logic [3:0]    list_pointer;
   logic          cycle_overrun;

   int checks = 0;
   int errors = 0;

   gate_list_executor #(
      .NUM_QUEUES(NQ), .LIST_DEPTH(LD), .INTERVAL_W(20), .INTERVAL_SHIFT(0), .GB_W(20)
   ) dut (
      .clk(clk), .rst_n(rst_n), .gate_enable(gate_enable), .cycle_start(cycle_start),
      .admin_gate_states(admin_gate_states), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
      .cfg_entry(cfg_entry), .cfg_interval(cfg_interval), .cfg_list_len_wr(cfg_list_len_wr),
      .cfg_list_len(cfg_list_len), .cfg_guard_band(cfg_guard_band), .cfg_commit(cfg_commit),
      .config_pending(config_pending), .out_gate_states(out_gate_states),
      .list_pointer(list_pointer), .cycle_overrun(cycle_overrun)
   );

   always #5 clk = ~clk;

   // Reference model: lists as plain arrays, position tracked as clocks since cycle start
   logic [7:0] m_ag [LD]; bit m_af [LD]; int m_aiv [LD]; int m_alen; int m_agb;
   logic [7:0] m_og [LD]; bit m_of [LD]; int m_oiv [LD]; int m_olen; int m_ogb;
   int m_mode;            // 0 disabled, 1 waiting, 2 running
   int m_t;
   bit m_pend;
   bit m_ovr;
   logic [7:0] m_out;
   int m_ptr;

   function automatic void model_reset();
      for (int i = 0; i < LD; i++) begin
         m_ag[i] = 8'hFF; m_af[i] = 1'b0; m_aiv[i] = 1024;
         m_og[i] = 8'hFF; m_of[i] = 1'b0; m_oiv[i] = 1024;
      end
      m_alen = LD; m_olen = LD; m_agb = 3200; m_ogb = 3200;
      m_mode = 0; m_t = 0; m_pend = 1'b0; m_ovr = 1'b0; m_out = 8'hFF; m_ptr = 0;
   endfunction

   function automatic int dwell(input int iv);
      return (iv == 0) ? 1 : iv;
   endfunction

   function automatic int list_total();
      int s = 0;
      for (int i = 0; i < m_olen; i++) s += dwell(m_oiv[i]);
      return s;
   endfunction

   // Which entry covers clock m_t of the cycle, and whether its guard band is active
   function automatic void model_eval();
      int  start = 0;
      int  stop;
      bit  found = 1'b0;
      m_out = m_og[m_olen-1];
      m_ptr = m_olen - 1;
      for (int i = 0; i < m_olen; i++) begin
         stop = start + dwell(m_oiv[i]);
         if (!found && m_t < stop) begin
            found = 1'b1;
            m_ptr = i;
            m_out = (GB_EN && m_of[i] && m_t >= stop - m_ogb) ? 8'h00 : m_og[i];
         end
         start = stop;
      end
   endfunction

   function automatic void model_edge();
      int total;
      bit swp;
      if (!rst_n) begin
         model_reset();
         return;
      end
      total = list_total();
      swp   = 1'b0;
      m_ovr = 1'b0;
      if (!gate_enable) begin
         m_mode = 0; swp = m_pend;
      end else if (cycle_start) begin
         m_ovr  = (m_mode == 2) && (m_t < total);
         m_mode = 2; m_t = 0; swp = m_pend;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 2) begin
         m_t++;
      end
      if (swp) begin
         for (int i = 0; i < LD; i++) begin
            m_og[i] = m_ag[i]; m_of[i] = m_af[i]; m_oiv[i] = m_aiv[i];
         end
         m_olen = m_alen; m_ogb = m_agb; m_pend = 1'b0;
      end
      if (cfg_commit) m_pend = 1'b1;
      if (cfg_wr) begin
         m_ag[cfg_addr]  = cfg_entry[7:0];
         m_af[cfg_addr]  = cfg_entry[8];
         m_aiv[cfg_addr] = int'(cfg_interval);
      end
      if (cfg_list_len_wr) begin
         m_alen = (cfg_list_len == 0) ? 1 : ((int'(cfg_list_len) > LD) ? LD : int'(cfg_list_len));
         m_agb  = int'(cfg_guard_band);
      end
      if (m_mode == 0) begin
         m_out = admin_gate_states; m_ptr = 0;
      end else if (m_mode == 2) begin
         model_eval();
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: model follows the edge, DUT sampled on the falling edge, pulses cleared
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("model_out", 32'(out_gate_states), 32'(m_out));
      chk("model_ptr", 32'(list_pointer), 32'(m_ptr));
      chk("model_pending", 32'(config_pending), 32'(m_pend));
      chk("model_overrun", 32'(cycle_overrun), 32'(m_ovr));
      cycle_start = 1'b0; cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_list_len_wr = 1'b0;
   endtask

   task automatic wr_entry(input int addr, input logic [8:0] ent, input int iv);
      cfg_wr = 1'b1; cfg_addr = 4'(addr); cfg_entry = ent; cfg_interval = 20'(iv);
      step();
   endtask

   task automatic wr_len(input int len, input int gb);
      cfg_list_len_wr = 1'b1; cfg_list_len = 5'(len); cfg_guard_band = 20'(gb);
      step();
   endtask

   typedef struct {
      bit         en;
      bit         cs;
      int         reps;
      logic [7:0] exp_out;
      int         exp_ptr;
      bit         exp_ovr;
   } vec_t;

   vec_t vt [15];

   initial begin
      vt[0]  = '{1'b1, 1'b1, 1, 8'h01, 0, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 4, 8'h01, 0, 1'b0};
      vt[2]  = '{1'b1, 1'b0, 3, 8'h02, 1, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 4, 8'h04, 2, 1'b0};
      vt[4]  = '{1'b1, 1'b0, 5, 8'h04, 2, 1'b0};
      vt[5]  = '{1'b1, 1'b1, 1, 8'h01, 0, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 4, 8'h01, 0, 1'b0};
      vt[7]  = '{1'b1, 1'b0, 1, 8'h02, 1, 1'b0};
      vt[8]  = '{1'b1, 1'b1, 1, 8'h01, 0, 1'b1};
      vt[9]  = '{1'b0, 1'b0, 1, 8'h5A, 0, 1'b0};
      vt[10] = '{1'b0, 1'b0, 2, 8'h5A, 0, 1'b0};
      vt[11] = '{1'b1, 1'b0, 3, 8'h5A, 0, 1'b0};
      vt[12] = '{1'b1, 1'b1, 1, 8'h01, 0, 1'b0};
      vt[13] = '{1'b0, 1'b1, 1, 8'h5A, 0, 1'b0};
      vt[14] = '{1'b1, 1'b0, 1, 8'h5A, 0, 1'b0};

      rst_n = 1'b0; gate_enable = 1'b0; cycle_start = 1'b0; admin_gate_states = 8'h5A;
      cfg_wr = 1'b0; cfg_addr = '0; cfg_entry = '0; cfg_interval = '0;
      cfg_list_len_wr = 1'b0; cfg_list_len = '0; cfg_guard_band = '0; cfg_commit = 1'b0;
      model_reset();

      // Reset values
      @(negedge clk);
      chk("rst_out", 32'(out_gate_states), 32'hFF);
      chk("rst_ptr", 32'(list_pointer), 32'h0);
      chk("rst_pending", 32'(config_pending), 32'h0);
      chk("rst_overrun", 32'(cycle_overrun), 32'h0);
      rst_n = 1'b1;

      // Three-entry list, committed while disabled so it swaps at once
      step();
      wr_entry(0, 9'h001, 5);
      wr_entry(1, 9'h002, 3);
      wr_entry(2, 9'h004, 4);
      wr_len(3, 4);
      cfg_commit = 1'b1;
      step();
      chk("commit_pending", 32'(config_pending), 32'h1);
      step();
      chk("disabled_swap_pending", 32'(config_pending), 32'h0);
      gate_enable = 1'b1;
      step();

      // Directed table
      foreach (vt[k]) begin
         for (int r = 0; r < vt[k].reps; r++) begin
            gate_enable = vt[k].en;
            cycle_start = vt[k].cs && (r == 0);
            step();
            chk($sformatf("tbl%0d_out", k), 32'(out_gate_states), 32'(vt[k].exp_out));
            chk($sformatf("tbl%0d_ptr", k), 32'(list_pointer), 32'(vt[k].exp_ptr));
            chk($sformatf("tbl%0d_ovr", k), 32'(cycle_overrun), 32'(vt[k].exp_ovr));
         end
      end

      // Guard-band entry: interval 10, guard band 4
      wr_entry(1, 9'h102, 10);
      cfg_commit = 1'b1;
      step();
      cycle_start = 1'b1;
      step();
      chk("gb_swap_out", 32'(out_gate_states), 32'h01);
      for (int i = 0; i < 4; i++) step();
      for (int i = 0; i < 10; i++) begin
         step();
         chk("gb_entry1", 32'(out_gate_states), (GB_EN && i >= 6) ? 32'h00 : 32'h02);
      end

      // Commit mid-cycle: old list keeps running, new list takes over at next cycle start
      wr_entry(0, 9'h080, 5);
      cfg_commit = 1'b1;
      step();
      chk("mid_pending", 32'(config_pending), 32'h1);
      chk("mid_old_list", 32'(out_gate_states), 32'h04);
      for (int i = 0; i < 5; i++) step();
      cycle_start = 1'b1;
      step();
      chk("new_list_out", 32'(out_gate_states), 32'h80);
      chk("new_list_pending", 32'(config_pending), 32'h0);

      // Commit and config write on the swap edge itself
      cfg_commit = 1'b1;
      step();
      cycle_start = 1'b1; cfg_commit = 1'b1;
      cfg_wr = 1'b1; cfg_addr = 4'd0; cfg_entry = 9'h033; cfg_interval = 20'd2;
      step();
      chk("swap_edge_out", 32'(out_gate_states), 32'h80);
      chk("swap_edge_pending", 32'(config_pending), 32'h1);
      step();
      cycle_start = 1'b1;
      step();
      chk("swap_edge_write_out", 32'(out_gate_states), 32'h33);
      chk("swap_edge_write_pending", 32'(config_pending), 32'h0);

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         gate_enable       = ($urandom_range(0, 99) < 97);
         cycle_start       = ($urandom_range(0, 99) < 3);
         admin_gate_states = 8'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            cfg_wr = 1'b1; cfg_addr = 4'($urandom);
            cfg_entry = 9'($urandom); cfg_interval = 20'($urandom_range(0, 12));
         end
         if ($urandom_range(0, 99) < 3) begin
            cfg_list_len_wr = 1'b1; cfg_list_len = 5'($urandom_range(0, 16));
            cfg_guard_band = 20'($urandom_range(0, 10));
         end
         cfg_commit = ($urandom_range(0, 99) < 4);
         step();
      end

      // Reset in the middle of a running cycle restores both banks
      gate_enable = 1'b1;
      wr_entry(0, 9'h011, 7);
      cfg_commit = 1'b1;
      step();
      cycle_start = 1'b1;
      step();
      step();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_out", 32'(out_gate_states), 32'hFF);
      chk("midrst_ptr", 32'(list_pointer), 32'h0);
      chk("midrst_pending", 32'(config_pending), 32'h0);
      step();
      step();
      rst_n = 1'b1;
      step();
      cycle_start = 1'b1;
      step();
      chk("post_rst_out", 32'(out_gate_states), 32'hFF);
      for (int i = 0; i < 1023; i++) step();
      chk("post_rst_ptr_last", 32'(list_pointer), 32'h0);
      step();
      chk("post_rst_ptr_next", 32'(list_pointer), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
